run_sequencer: RTL and testbench

Synthesizable run controller that drives a core's reset/req/done handshake for NUM_RUNS back-to-back program runs.
- Holds the core in reset, issues a one-cycle req, then waits for done or a timeout.
- Reports a per-run cycle count, timeout flag and run index.
- Sits between the top-level stimulus (bench or host) and a top_level core instance. It replaces hand-timed reset/wait sequencing with a reusable, parametrised block.

---
 rtl/run_sequencer_if.sv | 32 +++
 rtl/run_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_run_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_sequencer_if.sv
// Handshake bundle between the run sequencer and whoever drives it.
// master: the sequencer (drives the core controls and the result fields).
// slave : the stimulus/core side (drives start, abort and core_done).
interface run_sequencer_if #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             core_done;
    logic             core_reset;
    logic             core_req;
    logic [IDX_W-1:0] run_idx;
    logic             busy;
    logic             res_valid;
    logic [CNT_W-1:0] res_cycles;
    logic             res_timeout;
    logic             all_done;
    logic [CNT_W-1:0] max_cycles;

    modport master (
        input  start, abort, core_done,
        output core_reset, core_req, run_idx, busy, res_valid,
               res_cycles, res_timeout, all_done, max_cycles
    );

    modport slave (
        output start, abort, core_done,
        input  core_reset, core_req, run_idx, busy, res_valid,
               res_cycles, res_timeout, all_done, max_cycles
    );
endinterface

// File: rtl/run_sequencer.sv
// Run controller: holds the core in reset, pulses core_req, waits for
// core_done or a timeout and reports per-run results, NUM_RUNS times per start.
// Optional macro RUN_SEQ_STATS_EN enables the max_cycles tracker; without it
// max_cycles is a constant zero.
module run_sequencer #(
    parameter int NUM_RUNS   = 4,
    parameter int RST_CYCLES = 5,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             reset,
    run_sequencer_if.master bus
);
    localparam int IDX_W  = $clog2(NUM_RUNS > 1 ? NUM_RUNS : 2);
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);

    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_RUNS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES);

    typedef enum logic [2:0] {
        IDLE, HOLD_RST, REQ, WAIT, RECORD, FINISH
    } state_t;

    state_t            state, state_d;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
    logic [CNT_W-1:0]  cyc_cnt, cyc_cnt_d, cyc_inc;
    logic [IDX_W-1:0]  run_idx_q, run_idx_d;
    logic [CNT_W-1:0]  res_cycles_q, res_cycles_d;
    logic              core_reset_q, core_reset_d;
    logic              core_req_q, core_req_d;
    logic              busy_q, busy_d;
    logic              res_valid_q, res_valid_d;
    logic              res_timeout_q, res_timeout_d;
    logic              all_done_q, all_done_d;

`ifdef RUN_SEQ_STATS_EN
    logic [CNT_W-1:0]  max_q, max_d;

    function automatic logic [CNT_W-1:0] larger(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction
`endif

    assign cyc_inc = cyc_cnt + CNT_W'(1);

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d       = state;
        hold_cnt_d    = hold_cnt;
        cyc_cnt_d     = cyc_cnt;
        run_idx_d     = run_idx_q;
        res_cycles_d  = res_cycles_q;
        res_timeout_d = res_timeout_q;
        core_reset_d  = 1'b1;
        core_req_d    = 1'b0;
        busy_d        = busy_q;
        res_valid_d   = 1'b0;
        all_done_d    = all_done_q;
`ifdef RUN_SEQ_STATS_EN
        max_d         = max_q;
`endif

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d    = HOLD_RST;
                    run_idx_d  = '0;
                    all_done_d = 1'b0;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            HOLD_RST: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_d      = REQ;
                    core_req_d   = 1'b1;
                    core_reset_d = 1'b0;
                    cyc_cnt_d    = '0;
                end else begin
                    hold_cnt_d = hold_cnt + HOLD_W'(1);
                end
            end
            REQ: begin
                state_d      = WAIT;
                core_reset_d = 1'b0;
            end
            WAIT: begin
                core_reset_d = 1'b0;
                // done is checked first so a done on the last allowed cycle
                // is reported as a normal completion
                if (bus.core_done) begin
                    state_d       = RECORD;
                    res_cycles_d  = cyc_inc;
                    res_timeout_d = 1'b0;
                    res_valid_d   = 1'b1;
                end else if (cyc_inc == TIMEOUT_C) begin
                    state_d       = RECORD;
                    res_cycles_d  = TIMEOUT_C;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                end else begin
                    cyc_cnt_d = cyc_inc;
                end
            end
            RECORD: begin
                if (run_idx_q == LAST_IDX) begin
                    state_d    = FINISH;
                    busy_d     = 1'b0;
                    all_done_d = 1'b1;
                end else begin
                    state_d    = HOLD_RST;
                    run_idx_d  = run_idx_q + IDX_W'(1);
                    hold_cnt_d = '0;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // abort overrides whatever the current state decided
        if (bus.abort && state != IDLE) begin
            state_d       = IDLE;
            core_reset_d  = 1'b1;
            core_req_d    = 1'b0;
            busy_d        = 1'b0;
            all_done_d    = 1'b0;
            res_valid_d   = 1'b0;
            res_cycles_d  = res_cycles_q;
            res_timeout_d = res_timeout_q;
        end

`ifdef RUN_SEQ_STATS_EN
        if (state == IDLE && bus.start)
            max_d = '0;
        else if (res_valid_d)
            max_d = larger(max_q, res_cycles_d);
`endif
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            cyc_cnt       <= '0;
            run_idx_q     <= '0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
            core_reset_q  <= 1'b1;
            core_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            all_done_q    <= 1'b0;
        end else begin
            state         <= state_d;
            hold_cnt      <= hold_cnt_d;
            cyc_cnt       <= cyc_cnt_d;
            run_idx_q     <= run_idx_d;
            res_cycles_q  <= res_cycles_d;
            res_timeout_q <= res_timeout_d;
            core_reset_q  <= core_reset_d;
            core_req_q    <= core_req_d;
            busy_q        <= busy_d;
            res_valid_q   <= res_valid_d;
            all_done_q    <= all_done_d;
        end
    end

`ifdef RUN_SEQ_STATS_EN
    // Running maximum of the results in the current sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            max_q <= '0;
        else
            max_q <= max_d;
    end

    assign bus.max_cycles = max_q;
`else
    assign bus.max_cycles = '0;
`endif

    assign bus.core_reset  = core_reset_q;
    assign bus.core_req    = core_req_q;
    assign bus.run_idx     = run_idx_q;
    assign bus.busy        = busy_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_cycles  = res_cycles_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.all_done    = all_done_q;
endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with NUM_RUNS=2, RST_CYCLES=5, TIMEOUT=16.
`timescale 1ns/1ps
module tb_run_sequencer;
    localparam int NUM_RUNS   = 2;
    localparam int RST_CYCLES = 5;
    localparam int TIMEOUT    = 16;
    localparam int CNT_W      = 16;
    localparam int IDX_W      = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    run_sequencer_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bif ();

    run_sequencer #(
        .NUM_RUNS  (NUM_RUNS),
        .RST_CYCLES(RST_CYCLES),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    int vectors = 0;
    int errors  = 0;

    // observations gathered by run_core
    int               nval, nreq, first_req, fin;
    logic [CNT_W-1:0] got_cyc [0:3];
    logic             got_to  [0:3];
    logic [IDX_W-1:0] got_idx [0:3];
    logic             fin_rst;
    logic [CNT_W-1:0] fin_max;

    // one-cycle start pulse sampled in IDLE; returns just after the sampling edge
    task automatic start_seq;
        @(negedge clk);
        bif.start = 1'b1;
        @(posedge clk);
        #1 bif.start = 1'b0;
    endtask

    // core model: raises done for one cycle d cycles after each req (0 = never)
    task automatic run_core(input int d0, input int d1, input bit hold_glitch,
                            input bit start_glitch);
        int since;
        int dly;
        since = -1; dly = 0; nval = 0; nreq = 0; first_req = -1; fin = 0;
        for (int c = 0; c < 200 && fin == 0; c++) begin
            @(negedge clk);
            if (bif.core_req) begin
                if (first_req < 0) first_req = c;
                vectors++;
                if (bif.core_reset !== 1'b0) begin
                    errors++;
                    $display("FAIL req_core_reset: got %b want 0", bif.core_reset);
                end
                since = 0;
                dly   = (nreq == 0) ? d0 : d1;
                nreq++;
            end else if (since >= 0) begin
                since++;
            end
            if (bif.res_valid) begin
                if (nval < 4) begin
                    got_cyc[nval] = bif.res_cycles;
                    got_to[nval]  = bif.res_timeout;
                    got_idx[nval] = bif.run_idx;
                end
                nval++;
            end
            if (bif.all_done && !bif.busy) begin
                fin     = 1;
                fin_rst = bif.core_reset;
                fin_max = bif.max_cycles;
            end
            bif.core_done = (since > 0 && dly > 0 && since == dly) || (hold_glitch && c == 2);
            bif.start     = start_glitch && (c == 20);
        end
        bif.core_done = 1'b0;
        bif.start     = 1'b0;
        vectors++;
        if (fin == 0) begin
            errors++;
            $display("FAIL seq_finish: all_done not seen within 200 cycles");
        end
    endtask

    task automatic test_reset;
        int pulses;
        bif.start = 1'b0; bif.abort = 1'b0; bif.core_done = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bif.res_cycles !== 16'd0 || bif.run_idx !== 1'b0 || bif.max_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_fields: cycles=%0d idx=%0d max=%0d want 0/0/0",
                     bif.res_cycles, bif.run_idx, bif.max_cycles);
        end
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bif.res_valid || bif.core_req) pulses++;
            vectors++;
            if (bif.core_reset !== 1'b1 || bif.busy !== 1'b0 || bif.all_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: core_reset=%b busy=%b all_done=%b want 1/0/0",
                         bif.core_reset, bif.busy, bif.all_done);
            end
        end
        vectors++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_pulses: got %0d res_valid/core_req cycles want 0", pulses);
        end
    endtask

    task automatic test_normal;
        start_seq();
        run_core(10, 10, 1'b0, 1'b0);
        vectors++;
        if (first_req != 6) begin
            errors++;
            $display("FAIL normal_req_time: got %0d want 6", first_req);
        end
        vectors++;
        if (nreq != 2 || nval != 2) begin
            errors++;
            $display("FAIL normal_counts: req=%0d valid=%0d want 2/2", nreq, nval);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (got_cyc[i] !== 16'd10 || got_to[i] !== 1'b0 || got_idx[i] !== IDX_W'(i)) begin
                errors++;
                $display("FAIL normal_run%0d: cycles=%0d to=%b idx=%0d want 10/0/%0d",
                         i, got_cyc[i], got_to[i], got_idx[i], i);
            end
        end
        vectors++;
        if (fin_rst !== 1'b1) begin
            errors++;
            $display("FAIL normal_fin_core_reset: got %b want 1", fin_rst);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (bif.all_done !== 1'b1 || bif.busy !== 1'b0 || bif.core_reset !== 1'b1) begin
            errors++;
            $display("FAIL normal_idle_after: all_done=%b busy=%b core_reset=%b want 1/0/1",
                     bif.all_done, bif.busy, bif.core_reset);
        end
    endtask

    // run 0: done on the 16th WAIT cycle (race), run 1: no done (timeout);
    // also a done glitch in HOLD_RST and a start pulse while busy
    task automatic test_timeout_race;
        start_seq();
        run_core(16, 0, 1'b1, 1'b1);
        vectors++;
        if (first_req != 6 || nreq != 2 || nval != 2) begin
            errors++;
            $display("FAIL tmo_counts: first_req=%0d req=%0d valid=%0d want 6/2/2",
                     first_req, nreq, nval);
        end
        vectors++;
        if (got_cyc[0] !== 16'd16 || got_to[0] !== 1'b0 || got_idx[0] !== 1'b0) begin
            errors++;
            $display("FAIL race_run0: cycles=%0d to=%b idx=%0d want 16/0/0",
                     got_cyc[0], got_to[0], got_idx[0]);
        end
        vectors++;
        if (got_cyc[1] !== 16'd16 || got_to[1] !== 1'b1 || got_idx[1] !== 1'b1) begin
            errors++;
            $display("FAIL tmo_run1: cycles=%0d to=%b idx=%0d want 16/1/1",
                     got_cyc[1], got_to[1], got_idx[1]);
        end
    endtask

    task automatic test_abort;
        int pulses;
        start_seq();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                vectors++;
                if (bif.all_done !== 1'b0 || bif.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL start_clears_done: all_done=%b busy=%b want 0/1",
                             bif.all_done, bif.busy);
                end
            end
        end
        bif.abort = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
        vectors++;
        if (bif.busy !== 1'b0 || bif.core_reset !== 1'b1 || bif.core_req !== 1'b0 ||
            bif.all_done !== 1'b0 || bif.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b core_reset=%b req=%b all_done=%b valid=%b want 0/1/0/0/0",
                     bif.busy, bif.core_reset, bif.core_req, bif.all_done, bif.res_valid);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bif.res_valid || bif.core_req || bif.busy) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", pulses);
        end
    endtask

    // asynchronous reset between edges in WAIT of run 1 (after run 0 recorded 16)
    task automatic test_async_reset;
        bif.core_done = 1'b0;
        start_seq();
        repeat (36) @(negedge clk);
        vectors++;
        if (bif.busy !== 1'b1 || bif.core_reset !== 1'b0 || bif.run_idx !== 1'b1 ||
            bif.res_cycles !== 16'd16) begin
            errors++;
            $display("FAIL pre_reset_state: busy=%b core_reset=%b idx=%0d cycles=%0d want 1/0/1/16",
                     bif.busy, bif.core_reset, bif.run_idx, bif.res_cycles);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (bif.core_reset !== 1'b1 || bif.busy !== 1'b0 || bif.run_idx !== 1'b0 ||
            bif.res_cycles !== 16'd0 || bif.res_timeout !== 1'b0 || bif.all_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: core_reset=%b busy=%b idx=%0d cycles=%0d to=%b done=%b want 1/0/0/0/0/0",
                     bif.core_reset, bif.busy, bif.run_idx, bif.res_cycles,
                     bif.res_timeout, bif.all_done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stats;
        logic [CNT_W-1:0] exp_max;
`ifdef RUN_SEQ_STATS_EN
        exp_max = 16'd12;
`else
        exp_max = 16'd0;
`endif
        start_seq();
        run_core(7, 12, 1'b0, 1'b0);
        vectors++;
        if (nval != 2 || got_cyc[0] !== 16'd7 || got_cyc[1] !== 16'd12) begin
            errors++;
            $display("FAIL stats_runs: valid=%0d c0=%0d c1=%0d want 2/7/12",
                     nval, got_cyc[0], got_cyc[1]);
        end
        vectors++;
        if (fin_max !== exp_max) begin
            errors++;
            $display("FAIL stats_max: got %0d want %0d", fin_max, exp_max);
        end
        start_seq();
        @(negedge clk);
        vectors++;
        if (bif.max_cycles !== 16'd0 || bif.all_done !== 1'b0) begin
            errors++;
            $display("FAIL stats_clear: max=%0d all_done=%b want 0/0", bif.max_cycles, bif.all_done);
        end
        bif.abort = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
    endtask

    initial begin
        bif.start     = 1'b0;
        bif.abort     = 1'b0;
        bif.core_done = 1'b0;
        test_reset();
        test_normal();
        test_timeout_race();
        test_abort();
        test_async_reset();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
